// File: rtl/icache_responder_if.sv
// icache_responder_if
//   Groups the instruction-fetch handshake (datapath side) and the single-word
//   fill handshake (memory-controller side) of the instruction cache.
//
//   Signals:
//     imemREN   fetch request from datapath
//     imemaddr  fetch byte address from datapath
//     ihit      fetch data valid this cycle
//     imemload  fetched instruction word
//     iREN      fill read request to memory controller
//     iaddr     fill word address (bits [1:0] always 0)
//     iwait     memory controller busy
//     iload     fill data from memory controller
//
//   Modports:
//     slave   the cache itself (answers fetches, issues fills)
//     master  the surroundings (datapath + memory controller) driving the cache
interface icache_responder_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_responder.sv
// icache_responder
//   Direct-mapped, one-word-per-block instruction cache. Hits are answered in
//   the same cycle from the tag/data arrays; a miss parks the FSM in FETCH and
//   issues a single-word read to the memory controller until iwait drops,
//   then writes the block and returns to IDLE, where the request hits.
//
//   Ports:
//     CLK         clock
//     nRST        asynchronous active-low reset
//     bus         icache_responder_if.slave (fetch side + fill side)
//     hit_count   (ICACHE_STATS_EN only) cycles with ihit=1, wraps
//     miss_count  (ICACHE_STATS_EN only) IDLE->FETCH transitions, wraps
//
//   Parameters:
//     INDEX_BITS  index width; 2**INDEX_BITS blocks. Tag width is derived.
//
//   Optional feature macro: ICACHE_STATS_EN (hit/miss counters).
module icache_responder #(
    parameter int INDEX_BITS = 4
) (
    input  logic                    CLK,
    input  logic                    nRST,
    icache_responder_if.slave       bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
`endif
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int NBLOCKS  = 2 ** INDEX_BITS;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t                     state;
    logic [NBLOCKS-1:0]         valid;
    logic [TAG_BITS-1:0]        tagarr  [NBLOCKS];
    logic [31:0]                dataarr [NBLOCKS];

    logic [INDEX_BITS-1:0]      idx;
    logic [TAG_BITS-1:0]        tag;
    logic [INDEX_BITS-1:0]      fill_idx;
    logic [TAG_BITS-1:0]        fill_tag;
    logic                       lookup_hit;
    logic                       miss_req;
    logic                       fill_done;

    // Byte offset within the word is irrelevant to a word-granular cache.
    logic                       unused_byte_offset;
    assign unused_byte_offset = ^bus.imemaddr[1:0];

    assign idx = bus.imemaddr[INDEX_BITS+1:2];
    assign tag = bus.imemaddr[31:INDEX_BITS+2];

    // iaddr is the registered miss address for the whole FETCH pass, so the
    // fill index/tag come from it rather than from the live fetch address,
    // which may wander while the fill is outstanding.
    assign fill_idx = bus.iaddr[INDEX_BITS+1:2];
    assign fill_tag = bus.iaddr[31:INDEX_BITS+2];

    assign lookup_hit = valid[idx] && (tagarr[idx] == tag);
    assign bus.ihit     = bus.imemREN && (state == IDLE) && lookup_hit;
    assign bus.imemload = bus.ihit ? dataarr[idx] : 32'h0;

    assign miss_req  = (state == IDLE) && bus.imemREN && !lookup_hit;
    assign fill_done = (state == FETCH) && !bus.iwait;

    // Control FSM. iREN/iaddr are registered alongside the state so that the
    // asynchronous reset drops the fill request immediately.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            valid    <= '0;
            bus.iREN <= 1'b0;
            bus.iaddr <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        state     <= FETCH;
                        bus.iREN  <= 1'b1;
                        bus.iaddr <= {bus.imemaddr[31:2], 2'b00};
                    end
                end
                FETCH: begin
                    if (!bus.iwait) begin
                        state           <= IDLE;
                        valid[fill_idx] <= 1'b1;
                        bus.iREN        <= 1'b0;
                        bus.iaddr       <= 32'h0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.iREN  <= 1'b0;
                    bus.iaddr <= 32'h0;
                end
            endcase
        end
    end

    // Tag/data storage carries no reset; the valid bits alone decide whether
    // an entry is usable. A fill overwrites the block unconditionally.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tagarr[fill_idx]  <= fill_tag;
            dataarr[fill_idx] <= bus.iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (bus.ihit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_req) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
